// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory, next-PC select.
// Optional FETCH_MISALIGN_TRAP_EN traps a misaligned next PC instead of silently aligning it.
//
// state | meaning
// IDLE  | just out of reset, fetch begins next cycle
// FETCH | request outstanding at pc, waiting for imem_ack
// HOLD  | instr valid, waiting for datapath to consume it
// TRAP  | misaligned next PC seen, parked until reset (trap build only)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] TRAP  = 2'd3;
`endif

  logic [1:0]  state;
  logic [31:0] branch_target;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_pc       = {pc_plus4[31:28], jump_target, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_pc;
    else if (branch_taken)
      next_pc = branch_target;
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign op          = instr[31:26];
  assign funct       = instr[5:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  assign fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            // pc is left at the offending instruction so it can be inspected
            if (next_pc[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state   <= TRAP;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign fault = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc    <= next_pc & 32'hFFFF_FFFC;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed fetch stream, hold/spurious-ack,
// branch/jump priority, PC wrap, reset mid-fetch, and a misaligned-reset-PC instance.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  // second instance with a deliberately misaligned reset PC
  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [5:0]  op2;
  logic [5:0]  funct2;
  logic        valid2;
  logic [31:0] pc2;
  logic [31:0] pc_plus4_2;
  logic        fault2;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  instr_fetch_unit #(.RESET_PC(32'h0000_0002)) dut_mis (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .instr(instr2), .op(op2), .funct(funct2), .instr_valid(valid2), .instr_ready(1'b1),
    .branch_taken(1'b0), .branch_imm(16'h0), .jump(1'b0), .jump_target(26'h0),
    .pc(pc2), .pc_plus4(pc_plus4_2), .fault(fault2)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } fetch_t;

  fetch_t exp_q[$];
  fetch_t cur_e;
  int n_pass  = 0;
  int n_total = 0;
  int mem_lat = 0;
  int wcnt    = 0;
  logic spur      = 1'b0;
  logic force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0020;
      32'h0000_0004: return 32'h8C22_0004;
      32'h0000_0008: return 32'h0043_2022;
      32'h0000_000C: return 32'h0800_0010;
      32'h0000_0040: return 32'h1000_FFFE;
      32'h0000_003C: return 32'h2021_0001;
      default:       return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  // instruction memory model, driven just after the falling edge
  always @(negedge clk) begin
    #1;
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hBADB_AD01;
      wcnt       = 0;
    end else if (imem_req) begin
      if (wcnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        wcnt++;
      end
    end else begin
      imem_ack   = spur;
      imem_rdata = 32'h5555_AAAA;
      wcnt       = 0;
    end
  end

  always @(negedge clk) begin
    #1;
    ack2   = req2;
    rdata2 = 32'h0000_0020;
  end

  // monitor: checks every request address and every newly valid instruction
  int   cyc = 0;
  int   req_cyc = 0;
  logic req_d = 1'b0;
  logic valid_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      req_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      if (imem_req) begin
        if (!req_d) req_cyc = cyc;
        if (exp_q.size() == 0) begin
          if (!req_d) begin
            n_total++;
            $display("FAIL unexpected_req: request at %h, expected none", imem_addr);
          end
        end else begin
          chk("req_addr", imem_addr, exp_q[0].addr);
        end
      end
      if (instr_valid && !valid_d) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_valid: instr %h at pc %h, expected none", instr, pc);
        end else begin
          cur_e = exp_q.pop_front();
          chk("instr", instr, cur_e.data);
          chk("op", 32'(op), 32'(cur_e.data[31:26]));
          chk("funct", 32'(funct), 32'(cur_e.data[5:0]));
          chk("pc", pc, cur_e.addr);
          chk("pc_plus4", pc_plus4, cur_e.addr + 32'd4);
          chk("latency", 32'(cyc - req_cyc), 32'(cur_e.lat + 1));
        end
      end
      req_d   = imem_req;
      valid_d = instr_valid;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input int l);
    fetch_t e;
    e.addr = a;
    e.data = d;
    e.lat  = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      n_total++;
      $display("FAIL valid_timeout: instr_valid still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic step(input int nl, input logic br, input logic [15:0] imm,
                      input logic j, input logic [25:0] jt);
    wait_valid();
    mem_lat      = nl;
    instr_ready  = 1'b1;
    branch_taken = br;
    branch_imm   = imm;
    jump         = j;
    jump_target  = jt;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = 16'h0;
    jump         = 1'b0;
    jump_target  = 26'h0;
  endtask

  initial begin
    rst_n        = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = 16'h0;
    jump         = 1'b0;
    jump_target  = 26'h0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    ack2         = 1'b0;
    rdata2       = 32'h0;
    mem_lat      = 0;

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("mis_rst_pc", pc2, 32'h2);

    push(32'h0, 32'h0000_0020, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'h1);
    chk("mis_first_addr", addr2, 32'h2);
    @(negedge clk);

    // hold with instr_ready low and spurious acks
    for (int i = 0; i < 5; i++) begin
      chk("hold_instr", instr, 32'h0000_0020);
      chk("hold_pc", pc, 32'h0);
      chk("hold_req", 32'(imem_req), 32'h0);
      chk("hold_valid", 32'(instr_valid), 32'h1);
      if (i == 1) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_req", 32'(req2), 32'h0);
        chk("mis_fault", 32'(fault2), 32'h1);
        chk("mis_valid", 32'(valid2), 32'h0);
`else
        chk("mis_req", 32'(req2), 32'h1);
        chk("mis_addr", addr2, 32'h4);
        chk("mis_fault", 32'(fault2), 32'h0);
`endif
      end
      spur = (i % 2 == 0);
      @(negedge clk);
    end
    spur = 1'b0;

    // sequential stream with 3 wait cycles
    push(32'h4, 32'h8C22_0004, 3);
    push(32'h8, 32'h0043_2022, 3);
    push(32'hC, 32'h0800_0010, 3);
    step(3, 1'b0, 16'h0, 1'b0, 26'h0);
    step(3, 1'b0, 16'h0, 1'b0, 26'h0);
    step(3, 1'b0, 16'h0, 1'b0, 26'h0);

    // jump to 0x40, backward branch to 0x3C, jump beats branch, wrap to 0
    push(32'h40, 32'h1000_FFFE, 1);
    step(1, 1'b0, 16'h0, 1'b1, 26'h10);
    push(32'h3C, 32'h2021_0001, 1);
    step(1, 1'b1, 16'hFFFE, 1'b0, 26'h0);
    push(32'h40, 32'h1000_FFFE, 0);
    step(0, 1'b1, 16'h1234, 1'b1, 26'h10);
    push(32'hFFFF_FFFC, 32'hA5A5_FFFC, 0);
    step(0, 1'b1, 16'hFFEE, 1'b0, 26'h0);
    push(32'h0, 32'h0000_0020, 0);
    step(0, 1'b0, 16'h0, 1'b0, 26'h0);

    // reset while a fetch is waiting, with ack arriving during reset and in IDLE
    push(32'h4, 32'h8C22_0004, 3);
    step(3, 1'b0, 16'h0, 1'b0, 26'h0);
    @(negedge clk);
    rst_n     = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_fault", 32'(fault), 32'h0);
    exp_q.delete();
    push(32'h0, 32'h0000_0020, 0);
    mem_lat = 0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("idle_ack_ignored", instr, 32'h0);
    chk("rerelease_req", 32'(imem_req), 32'h1);
    force_ack = 1'b0;
    wait_valid();

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("final_fault", 32'(fault), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
